hz_smg_display: RTL and testbench

Converts a 10-bit binary frequency value (0–1023) into four BCD digits using a sequential double-dabble engine. Drives a 4-digit multiplexed common-anode seven-segment display with the result. It sits downstream of the frequency measurement logic, on the opposite side of the existing BCD-to-binary conversion. It is the path that puts the measured `hz` value back onto the `smg_duan`/`smg_wei` display pins.

---
 rtl/smg_pkg.sv | 58 +++++
 rtl/smg_scan.sv | 83 ++++++++
 rtl/hz_smg_display.sv | 91 +++++++++
 tb/tb_hz_smg_display.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/smg_pkg.sv
// Shared definitions for the hz_smg_display slice: FSM states, segment codes
// and the double-dabble step helper.
package smg_pkg;

  localparam int DIGITS = 4;

  // Active-low segment codes, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic [6:0] seg_encode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // One double-dabble iteration on the lower 13 accumulator bits; the
  // thousands nibble never reaches 5, so only the three low nibbles adjust.
  function automatic logic [13:0] dd_step(input logic [12:0] acc, input logic in_bit);
    logic [11:0] adj;
    for (int i = 0; i < 3; i++) begin
      if (acc[i*4 +: 4] >= 4'd5) begin
        adj[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
      end else begin
        adj[i*4 +: 4] = acc[i*4 +: 4];
      end
    end
    return {acc[12], adj, in_bit};
  endfunction

endpackage

// File: rtl/smg_scan.sv
// Digit scanner for a 4-digit common-anode display: free-running slot counter,
// digit select, segment encoding and optional leading-zero blanking
// (enabled by defining HZ_SMG_BLANK_EN).
module smg_scan
  import smg_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] bcd,
  output logic [6:0]  smg_duan,
  output logic [3:0]  smg_wei,
  output logic        dp
);

  localparam int CW = $clog2(SCAN_DIV);

  logic [CW-1:0] cnt_r;
  logic [1:0]    idx_r;
  logic [6:0]    duan_r;
  logic [3:0]    wei_r;
  logic          dp_r;
  logic [3:0]    nib_s;
  logic          blank_s;

  // Select the nibble for the current digit and decide whether it is a leading zero
  always_comb begin
    nib_s   = 4'd0;
    blank_s = 1'b0;
    case (idx_r)
      2'd0: begin
        nib_s   = bcd[3:0];
        blank_s = 1'b0;
      end
      2'd1: begin
        nib_s   = bcd[7:4];
        blank_s = (bcd[15:4] == 12'd0);
      end
      2'd2: begin
        nib_s   = bcd[11:8];
        blank_s = (bcd[15:8] == 8'd0);
      end
      2'd3: begin
        nib_s   = bcd[15:12];
        blank_s = (bcd[15:12] == 4'd0);
      end
      default: begin
        nib_s   = 4'd0;
        blank_s = 1'b0;
      end
    endcase
`ifndef HZ_SMG_BLANK_EN
    blank_s = 1'b0;
`endif
  end

  // Slot counter, digit index and registered display drive
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r  <= '0;
      idx_r  <= 2'd0;
      wei_r  <= 4'b1111;
      duan_r <= SEG_BLANK;
      dp_r   <= 1'b1;
    end else begin
      if (cnt_r == CW'(SCAN_DIV - 1)) begin
        cnt_r <= '0;
        idx_r <= idx_r + 2'd1;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
      wei_r  <= ~(4'b0001 << idx_r);
      duan_r <= blank_s ? SEG_BLANK : seg_encode(nib_s);
      dp_r   <= 1'b1;
    end
  end

  assign smg_duan = duan_r;
  assign smg_wei  = wei_r;
  assign dp       = dp_r;

endmodule

// File: rtl/hz_smg_display.sv
// Binary-to-BCD display path: sequential double-dabble conversion of hz into
// four BCD digits, shown on a multiplexed seven-segment display. Optional
// leading-zero blanking is selected with HZ_SMG_BLANK_EN.
module hz_smg_display
  import smg_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  hz,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd,
  output logic [6:0]  smg_duan,
  output logic [3:0]  smg_wei,
  output logic        dp
);

  state_t      state_r;
  logic [9:0]  sr_r;
  logic [13:0] acc_r;
  logic [3:0]  iter_r;
  logic        busy_r;
  logic        done_r;
  logic [15:0] bcd_r;

  // Conversion FSM: load, ten shift-and-adjust steps, publish result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      sr_r    <= 10'd0;
      acc_r   <= 14'd0;
      iter_r  <= 4'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      bcd_r   <= 16'd0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            sr_r    <= hz;
            acc_r   <= 14'd0;
            iter_r  <= 4'd0;
            busy_r  <= 1'b1;
            state_r <= SHIFT;
          end else begin
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          acc_r <= dd_step(acc_r[12:0], sr_r[9]);
          sr_r  <= {sr_r[8:0], 1'b0};
          if (iter_r == 4'd9) begin
            state_r <= DONE;
          end else begin
            iter_r <= iter_r + 4'd1;
          end
        end
        DONE: begin
          bcd_r   <= {2'b00, acc_r};
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign bcd  = bcd_r;

  smg_scan #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk      (clk),
    .rst_n    (rst_n),
    .bcd      (bcd_r),
    .smg_duan (smg_duan),
    .smg_wei  (smg_wei),
    .dp       (dp)
  );

endmodule

// File: tb/tb_hz_smg_display.sv
// Self-checking bench for hz_smg_display: table vectors, random values against
// an arithmetic BCD model, a per-cycle scan model and multi-cycle corner cases.
module tb_hz_smg_display;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  hz = 10'd0;
  logic        busy, done, dp;
  logic [15:0] bcd;
  logic [6:0]  smg_duan;
  logic [3:0]  smg_wei;

  int nvec = 0;
  int nerr = 0;
  int edges = 0;
  bit seen_rst = 1'b0;

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  typedef struct {
    logic [9:0]  hz;
    logic [15:0] exp_bcd;
  } vec_t;

  vec_t tab [9];

  hz_smg_display #(.SCAN_DIV(D)) dut (
    .clk(clk), .rst_n(rst_n), .hz(hz), .start(start), .busy(busy), .done(done),
    .bcd(bcd), .smg_duan(smg_duan), .smg_wei(smg_wei), .dp(dp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] exp_seg(input logic [15:0] b, input int d);
    logic [3:0] dig;
    bit lead;
    dig = b[d*4 +: 4];
    lead = (d > 0);
    for (int i = d; i < 4; i++) if (b[i*4 +: 4] != 4'd0) lead = 1'b0;
`ifdef HZ_SMG_BLANK_EN
    if (lead) return 7'h7F;
`endif
    return seg_tab[dig];
  endfunction

  // Count rising edges since reset release
  always @(posedge clk) begin
    if (!rst_n) begin
      edges    <= 0;
      seen_rst <= 1'b1;
    end else begin
      edges <= edges + 1;
    end
  end

  // Scan position model: digit slot follows elapsed cycles since reset
  always @(negedge clk) begin
    logic [3:0] ew;
    if (seen_rst) begin
      if (edges == 0) begin
        chk("wei_reset", {28'd0, smg_wei}, 32'hF);
        chk("duan_reset", {25'd0, smg_duan}, 32'h7F);
      end else begin
        ew = ~(4'b0001 << (((edges - 1) / D) % 4));
        chk("wei_scan", {28'd0, smg_wei}, {28'd0, ew});
      end
      chk("dp_off", {31'd0, dp}, 32'd1);
    end
  end

  task automatic run_conv(input logic [9:0] v, input logic [15:0] exp);
    int got;
    @(negedge clk);
    hz = v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    got = 0;
    for (int j = 1; j <= 15; j++) begin
      @(negedge clk);
      if (j == 10) chk("busy_k10", {31'd0, busy}, 32'd1);
      if (done) begin
        got = j;
        break;
      end
    end
    chk("done_latency", got, 32'd11);
    chk("busy_at_done", {31'd0, busy}, 32'd0);
    chk($sformatf("bcd_hz%0d", v), {16'd0, bcd}, {16'd0, exp});
  endtask

  task automatic check_display(input logic [15:0] exp);
    bit found;
    logic [3:0] tw;
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      tw = ~(4'b0001 << d);
      found = 1'b0;
      for (int c = 0; c < 4 * D + 4; c++) begin
        if (smg_wei == tw) begin
          found = 1'b1;
          break;
        end
        @(negedge clk);
      end
      chk($sformatf("slot_found_d%0d", d), {31'd0, found}, 32'd1);
      chk($sformatf("seg_%0h_d%0d", exp, d), {25'd0, smg_duan}, {25'd0, exp_seg(exp, d)});
    end
  endtask

  initial begin
    int v, ndone, dj1, dj2;
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int v, ndone, dj1, dj2;
    tab[0] = '{10'd0,    16'h0000};
    tab[1] = '{10'd1023, 16'h1023};
    tab[2] = '{10'd40,   16'h0040};
    tab[3] = '{10'd999,  16'h0999};
    tab[4] = '{10'd500,  16'h0500};
    tab[5] = '{10'd7,    16'h0007};
    tab[6] = '{10'd100,  16'h0100};
    tab[7] = '{10'd1,    16'h0001};
    tab[8] = '{10'd10,   16'h0010};

    // Reset held for three cycles
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wei", {28'd0, smg_wei}, 32'hF);
    chk("rst_duan", {25'd0, smg_duan}, 32'h7F);
    chk("rst_dp", {31'd0, dp}, 32'd1);
    chk("rst_bcd", {16'd0, bcd}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_wei", {28'd0, smg_wei}, 32'hE);
    chk("post_rst_duan", {25'd0, smg_duan}, 32'h40);

    for (int i = 0; i < 9; i++) begin
      run_conv(tab[i].hz, tab[i].exp_bcd);
      check_display(tab[i].exp_bcd);
    end

    for (int i = 0; i < 20; i++) begin
      v = int'($urandom_range(0, 1023));
      run_conv(10'(v), model_bcd(v));
      if (i % 4 == 0) check_display(model_bcd(v));
    end

    // Start while busy is dropped; restart right after DONE is taken
    @(negedge clk);
    hz = 10'd500;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0; dj1 = 0; dj2 = 0;
    for (int j = 1; j <= 26; j++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          dj1 = j;
          chk("busy_drop_bcd", {16'd0, bcd}, 32'h0500);
        end else begin
          dj2 = j;
        end
      end
      if (j == 3 || j == 11) begin
        hz = 10'd7;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    chk("busy_drop_ndone", ndone, 32'd2);
    chk("busy_drop_first", dj1, 32'd11);
    chk("restart_second", dj2, 32'd23);
    chk("restart_bcd", {16'd0, bcd}, 32'h0007);

    // Start during the DONE cycle is ignored
    @(negedge clk);
    hz = 10'd123;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int j = 1; j <= 30; j++) begin
      @(negedge clk);
      if (done) ndone++;
      if (j == 10) begin
        hz = 10'd9;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    chk("done_cycle_ndone", ndone, 32'd1);
    chk("done_cycle_bcd", {16'd0, bcd}, 32'h0123);

    // Reset mid-conversion aborts with no partial update
    @(negedge clk);
    hz = 10'd321;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_bcd", {16'd0, bcd}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("midrst_no_done", ndone, 32'd0);
    chk("midrst_bcd_after", {16'd0, bcd}, 32'd0);
    check_display(16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
